mmio_interconnect: RTL and testbench

- Parametrised successor to the fixed CPU/BRAM/FIFO memory map: one CPU master, NUM_SLAVES memory-mapped slaves.
- Address regions are set by parameters.
- Slaves get a req/ack handshake, so wait-states are allowed.
- Adds a bus timeout, registered responses, and sticky error flags that software can clear. The old design only had a combinational invalid-address line.

---
 rtl/mmio_pkg.sv | 11 +
 rtl/mmio_decode.sv | 24 ++
 rtl/mmio_interconnect.sv | 126 ++++++++++++
 tb/tb_mmio_interconnect.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared FSM states, default SoC map and counter sizing for the MMIO interconnect
package mmio_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam int DEFAULT_NUM_SLAVES = 2;
  // BRAM at 0x0000_0000 (64 KiB window), FIFO TX at exactly 0x0001_0000
  localparam logic [63:0] DEFAULT_BASE = {32'h0001_0000, 32'h0000_0000};
  localparam logic [63:0] DEFAULT_MASK = {32'hFFFF_FFFF, 32'hFFFF_0000};
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction
endpackage

// File: rtl/mmio_decode.sv
// mmio_decode: address to one-hot slave select, lowest matching index wins
module mmio_decode #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic                  hit_o
);
  // scan from the top so the lowest matching index is written last
  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        sel_o    = '0;
        sel_o[i] = 1'b1;
        hit_o    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mmio_interconnect.sv
// mmio_interconnect: single master to NUM_SLAVES req/ack slaves with timeout,
// registered responses and software-clearable sticky error flags
module mmio_interconnect
  import mmio_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT = 15
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_m_req,
  input  logic                             i_m_write,
  input  logic [ADDR_WIDTH-1:0]            i_m_addr,
  input  logic [DATA_WIDTH-1:0]            i_m_wdata,
  output logic                             o_m_ready,
  output logic                             o_m_rvalid,
  output logic [DATA_WIDTH-1:0]            o_m_rdata,
  output logic                             o_m_err,
  output logic [NUM_SLAVES-1:0]            o_s_req,
  output logic                             o_s_write,
  output logic [ADDR_WIDTH-1:0]            o_s_addr,
  output logic [DATA_WIDTH-1:0]            o_s_wdata,
  input  logic [NUM_SLAVES-1:0]            i_s_ack,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_s_rdata,
  input  logic                             i_err_clear,
  output logic                             o_invalid_addr,
  output logic                             o_timeout
);
  localparam int CW = cnt_width(TIMEOUT);
  state_e                state_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [CW-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, rdata_sel;
  logic                  write_q, rvalid_q, err_q, inv_q, to_q, inv_d, to_d;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_hit, ack_sel, limit, set_inv, set_to;
  mmio_decode #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_SLAVES(NUM_SLAVES),
    .SLAVE_BASE(SLAVE_BASE),
    .SLAVE_MASK(SLAVE_MASK)
  ) u_decode (
    .addr_i(i_m_addr),
    .sel_o (dec_sel),
    .hit_o (dec_hit)
  );
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      rdata_sel = rdata_sel | (i_s_rdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_q[i]}});
  end
  assign ack_sel = |(i_s_ack & sel_q);
  assign limit   = cnt_q == CW'(TIMEOUT - 1);
  assign set_inv = (state_q == IDLE) && i_m_req && !dec_hit;
  assign set_to  = (state_q == ACCESS) && !ack_sel && limit;
  // a set event outranks a simultaneous software clear
  assign inv_d   = set_inv | (inv_q & ~i_err_clear);
  assign to_d    = set_to | (to_q & ~i_err_clear);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      inv_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      inv_q    <= inv_d;
      to_q     <= to_d;
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: if (i_m_req) begin
          addr_q  <= i_m_addr;
          wdata_q <= i_m_wdata;
          write_q <= i_m_write;
          cnt_q   <= '0;
          if (dec_hit) begin
            sel_q   <= dec_sel;
            state_q <= ACCESS;
          end else begin
            err_q    <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b1;
            state_q  <= RESP;
          end
        end
        ACCESS: if (ack_sel) begin
          rdata_q  <= write_q ? '0 : rdata_sel;
          err_q    <= 1'b0;
          rvalid_q <= 1'b1;
          sel_q    <= '0;
          state_q  <= RESP;
        end else if (limit) begin
          rdata_q  <= '0;
          err_q    <= 1'b1;
          rvalid_q <= 1'b1;
          sel_q    <= '0;
          state_q  <= RESP;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_m_ready      = state_q == IDLE;
  assign o_m_rvalid     = rvalid_q;
  assign o_m_rdata      = rdata_q;
  assign o_m_err        = err_q;
  assign o_s_req        = sel_q;
  assign o_s_write      = write_q;
  assign o_s_addr       = addr_q;
  assign o_s_wdata      = wdata_q;
  assign o_invalid_addr = inv_q;
  assign o_timeout      = to_q;
endmodule

// File: tb/tb_mmio_interconnect.sv
// tb_mmio_interconnect: directed and randomized checks against a transaction-level reference model
module tb_mmio_interconnect;
  localparam int NS = 3;
  localparam int TO = 6;
  // slave2 overlaps slave0 and must never be selected
  localparam logic [NS*32-1:0] BASE = {32'h0000_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
  logic clk = 0, rst = 1, m_req = 0, m_write = 0, err_clear = 0;
  logic [31:0] m_addr = 0, m_wdata = 0;
  logic m_ready, m_rvalid, m_err, s_write, inv, tmo;
  logic [31:0] m_rdata, s_addr, s_wdata;
  logic [NS-1:0] s_req, s_ack, stray = 0;
  logic [NS*32-1:0] s_rdata;
  int lat[NS];
  logic [31:0] srd[NS];
  int scnt[NS];
  logic [31:0] base_a[NS] = '{32'h0, 32'h0001_0000, 32'h0};
  logic [31:0] mask_a[NS] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
  logic exp_inv = 0, exp_to = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mmio_interconnect #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(NS),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_m_req(m_req), .i_m_write(m_write),
    .i_m_addr(m_addr), .i_m_wdata(m_wdata), .o_m_ready(m_ready),
    .o_m_rvalid(m_rvalid), .o_m_rdata(m_rdata), .o_m_err(m_err),
    .o_s_req(s_req), .o_s_write(s_write), .o_s_addr(s_addr), .o_s_wdata(s_wdata),
    .i_s_ack(s_ack), .i_s_rdata(s_rdata), .i_err_clear(err_clear),
    .o_invalid_addr(inv), .o_timeout(tmo)
  );
  // slave models: lat[i]=n acks in the n-th requested cycle, 0 never acks
  always @(posedge clk)
    for (int i = 0; i < NS; i++) scnt[i] <= s_req[i] ? scnt[i] + 1 : 0;
  always_comb
    for (int i = 0; i < NS; i++) begin
      s_ack[i] = stray[i] | (s_req[i] && lat[i] != 0 && scnt[i] + 1 == lat[i]);
      s_rdata[i*32 +: 32] = srd[i];
    end
  function automatic int exp_sel(input logic [31:0] a);
    for (int i = 0; i < NS; i++) if ((a & mask_a[i]) == base_a[i]) return i;
    return -1;
  endfunction
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd, input logic clr);
    int s, n, exp_n;
    logic exp_err;
    logic [31:0] exp_rd;
    logic [NS-1:0] exp_req;
    s = exp_sel(addr);
    exp_req = '0;
    if (clr) begin exp_inv = 0; exp_to = 0; end
    if (s < 0) begin
      exp_err = 1; exp_rd = 0; exp_n = 1; exp_inv = 1;
    end else begin
      exp_req[s] = 1'b1;
      if (lat[s] >= 1 && lat[s] <= TO) begin exp_err = 0; exp_rd = wr ? 32'h0 : srd[s]; exp_n = lat[s] + 1; end
      else begin exp_err = 1; exp_rd = 0; exp_n = TO + 1; exp_to = 1; end
    end
    @(negedge clk);
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL ready_idle: got %b exp 1", m_ready); end
    m_req = 1; m_write = wr; m_addr = addr; m_wdata = wd; err_clear = clr;
    @(negedge clk);
    m_req = 0; err_clear = 0; m_write = ~wr; m_addr = $urandom; m_wdata = $urandom;
    n = 1;
    while (!m_rvalid && n <= TO + 4) begin
      checks++; if (s_req !== exp_req) begin errors++; $display("FAIL s_req: got %b exp %b", s_req, exp_req); end
      checks++; if (s_addr !== addr || s_wdata !== wd || s_write !== wr) begin
        errors++; $display("FAIL s_hold: got %h/%h/%b exp %h/%h/%b", s_addr, s_wdata, s_write, addr, wd, wr); end
      checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL ready_busy: got %b exp 0", m_ready); end
      @(negedge clk);
      n++;
    end
    checks++; if (n !== exp_n) begin errors++; $display("FAIL latency @%h: got %0d exp %0d", addr, n, exp_n); end
    checks++; if (m_rdata !== exp_rd) begin errors++; $display("FAIL rdata @%h: got %h exp %h", addr, m_rdata, exp_rd); end
    checks++; if (m_err !== exp_err) begin errors++; $display("FAIL err @%h: got %b exp %b", addr, m_err, exp_err); end
    checks++; if (s_req !== '0 || m_ready !== 1'b0) begin errors++; $display("FAIL resp_state: got req=%b ready=%b exp 0/0", s_req, m_ready); end
    checks++; if (inv !== exp_inv || tmo !== exp_to) begin
      errors++; $display("FAIL flags: got inv=%b to=%b exp %b/%b", inv, tmo, exp_inv, exp_to); end
    @(negedge clk);
    checks++; if (m_rvalid !== 1'b0 || m_ready !== 1'b1) begin
      errors++; $display("FAIL post_resp: got rvalid=%b ready=%b exp 0/1", m_rvalid, m_ready); end
  endtask
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++; if (m_ready !== 1'b1 || m_rvalid !== 1'b0 || m_err !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: got ready=%b rvalid=%b err=%b exp 1/0/0", m_ready, m_rvalid, m_err); end
    checks++; if (m_rdata !== 32'h0 || s_req !== '0) begin errors++; $display("FAIL reset_data: got %h/%b exp 0/0", m_rdata, s_req); end
    checks++; if (s_addr !== 32'h0 || s_wdata !== 32'h0 || s_write !== 1'b0) begin
      errors++; $display("FAIL reset_latch: got %h/%h/%b exp 0", s_addr, s_wdata, s_write); end
    checks++; if (inv !== 1'b0 || tmo !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b/%b exp 0/0", inv, tmo); end
    rst = 0;
    exp_inv = 0; exp_to = 0;
  endtask
  task automatic test_zero_wait_read();
    lat[1] = 1; srd[1] = 32'hDEAD_BEEF;
    txn(0, 32'h0001_0004, 32'h0, 0);
  endtask
  task automatic test_wait_write();
    lat[0] = 5; srd[0] = 32'hA5A5_A5A5;
    txn(1, 32'h0000_0010, 32'h1234_5678, 0);
  endtask
  task automatic test_decode_miss();
    txn(0, 32'h8000_0000, 32'h0, 0);
    repeat (3) @(negedge clk);
    checks++; if (inv !== 1'b1) begin errors++; $display("FAIL inv_sticky: got %b exp 1", inv); end
    err_clear = 1;
    @(negedge clk);
    err_clear = 0; exp_inv = 0; exp_to = 0;
    checks++; if (inv !== 1'b0) begin errors++; $display("FAIL inv_clear: got %b exp 0", inv); end
    txn(0, 32'h8000_0000, 32'h0, 1);
  endtask
  task automatic test_timeout();
    lat[0] = 0;
    txn(0, 32'h0000_0020, 32'h0, 0);
    lat[0] = TO; srd[0] = 32'h0BAD_F00D;
    txn(0, 32'h0000_0024, 32'h0, 0);
  endtask
  task automatic test_overlap_stray();
    lat[0] = 3; srd[0] = 32'hCAFE_0001; srd[2] = 32'hFFFF_FFFF;
    stray = 3'b110;
    txn(0, 32'h0000_0100, 32'h0, 0);
    stray = 0;
  endtask
  task automatic test_reset_mid();
    int seen;
    lat[1] = 0;
    @(negedge clk);
    m_req = 1; m_write = 0; m_addr = 32'h0001_0000;
    @(negedge clk);
    m_req = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++; if (s_req !== '0 || m_ready !== 1'b1 || m_rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got req=%b ready=%b rvalid=%b exp 0/1/0", s_req, m_ready, m_rvalid); end
    checks++; if (inv !== 1'b0 || tmo !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got %b/%b exp 0/0", inv, tmo); end
    rst = 0; exp_inv = 0; exp_to = 0;
    seen = 0;
    repeat (TO + 2) begin @(negedge clk); if (m_rvalid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_pulse: got %0d exp 0", seen); end
    lat[1] = 2; srd[1] = 32'h1357_9BDF;
    txn(0, 32'h0001_0008, 32'h0, 0);
  endtask
  task automatic test_random();
    logic [31:0] a;
    int s, r;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 2);
      a = (r == 0) ? {16'h0000, 16'($urandom)} : (r == 1) ? {16'h0001, 16'($urandom)}
                   : {16'($urandom_range(2, 16'hFFFF)), 16'($urandom)};
      for (int i = 0; i < NS; i++) begin lat[i] = $urandom_range(0, TO + 1); srd[i] = $urandom; end
      s = exp_sel(a);
      stray = NS'($urandom);
      if (s >= 0) stray[s] = 1'b0;
      txn(1'($urandom), a, $urandom, $urandom_range(0, 4) == 0);
      stray = 0;
    end
  endtask
  initial begin
    for (int i = 0; i < NS; i++) begin lat[i] = 1; srd[i] = 0; end
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_decode_miss();
    test_timeout();
    test_overlap_stray();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish exp finish");
    $fatal(1, "watchdog");
  end
endmodule
